// File: rtl/pending_priority_encoder_8_3_pkg.sv
// Shared types and sizes for the pending priority encoder.
// Consumed by the top and its priority-select sub-module.
package pending_priority_encoder_8_3_pkg;

    localparam int unsigned NumReq   = 8;
    localparam int unsigned EncWidth = 3;

    typedef enum logic {
        StIdle,
        StPresent
    } state_e;

endpackage

// File: rtl/pending_priority_encoder_8_3_priority_select.sv
// Combinational highest-set-index selector (Priority_Select_8_3):
// 8-bit request vector in, 3-bit index and any-set flag out.
module pending_priority_encoder_8_3_priority_select
    import pending_priority_encoder_8_3_pkg::*;
(
    input  logic [NumReq-1:0]   req_i,
    output logic [EncWidth-1:0] idx_o,
    output logic                any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        // Ascending scan: the last hit is the highest set index.
        for (int i = 0; i < NumReq; i++) begin
            if (req_i[i]) begin
                idx_o = EncWidth'(i);
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder_8_3.sv
// Sticky 8-line request register presented one index at a time over valid/ready.
// Optional macro EDGE_DETECT_EN captures rising edges instead of levels.
module pending_priority_encoder_8_3
    import pending_priority_encoder_8_3_pkg::*;
(
    input  logic       Clock_In,
    input  logic       Reset_n_In,
    input  logic       Enable_In,
    input  logic       Data_0_In,
    input  logic       Data_1_In,
    input  logic       Data_2_In,
    input  logic       Data_3_In,
    input  logic       Data_4_In,
    input  logic       Data_5_In,
    input  logic       Data_6_In,
    input  logic       Data_7_In,
    input  logic       Ready_In,
    output logic [2:0] Encoded_Value_Out,
    output logic       Valid_Out,
    output logic [7:0] Pending_Out
);

    logic [NumReq-1:0]   data_in;
    logic [NumReq-1:0]   capture;
    logic [NumReq-1:0]   clear_mask;
    logic [NumReq-1:0]   pend_q, pend_d;
    logic [EncWidth-1:0] enc_q, enc_d;
    logic [EncWidth-1:0] sel_idx;
    logic                sel_any;
    state_e              state_q, state_d;

    assign data_in = {Data_7_In, Data_6_In, Data_5_In, Data_4_In,
                      Data_3_In, Data_2_In, Data_1_In, Data_0_In};

`ifdef EDGE_DETECT_EN
    logic [NumReq-1:0] prev_q;

    // Previous sample tracks the lines regardless of Enable_In.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            prev_q <= '0;
        end else begin
            prev_q <= data_in;
        end
    end

    assign capture = Enable_In ? (data_in & ~prev_q) : '0;
`else
    assign capture = Enable_In ? data_in : '0;
`endif

    pending_priority_encoder_8_3_priority_select u_priority_select (
        .req_i (pend_q),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    always_comb begin
        state_d    = state_q;
        enc_d      = enc_q;
        clear_mask = '0;
        case (state_q)
            StIdle: begin
                if (sel_any) begin
                    enc_d   = sel_idx;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (Ready_In) begin
                    clear_mask[enc_q] = 1'b1;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Capture is OR-ed after the clear so a same-cycle re-request survives.
        pend_d = (pend_q & ~clear_mask) | capture;
    end

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_q <= StIdle;
            pend_q  <= '0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            enc_q   <= enc_d;
        end
    end

    assign Encoded_Value_Out = enc_q;
    assign Valid_Out         = (state_q == StPresent);
    assign Pending_Out       = pend_q;

endmodule
